led_fader: RTL and testbench

Downstream stage of the dynamic-LED colour sequencer. Consumes its 3-bit `colour` code and drives three PWM outputs for an RGB LED. Each colour change is rendered as a linear cross-fade rather than a hard switch. It sits between the sequencer and the board LED pins, in the same clock domain as the sequencer.

---
 rtl/led_pkg.sv | 22 ++
 rtl/led_fader_pwm_channel.sv | 42 ++++
 rtl/led_fader.sv | 111 +++++++++++
 tb/tb_led_fader.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared constants for the LED fader: channel indices, colour bit mapping
// and the fade FSM state encoding.
package led_pkg;

  localparam int NUM_CH = 3;

  // colour bit i drives channel i
  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;

  localparam logic [2:0] COLOUR_OFF   = 3'b000;
  localparam logic [2:0] COLOUR_RED   = 3'b001;
  localparam logic [2:0] COLOUR_GREEN = 3'b010;
  localparam logic [2:0] COLOUR_BLUE  = 3'b100;

  typedef enum logic {
    IDLE   = 1'b0,
    FADING = 1'b1
  } fade_state_t;

endpackage

// File: rtl/led_fader_pwm_channel.sv
// One fader channel: working duty that ramps toward on/off, a shadow copy
// taken at the PWM period boundary, and the registered PWM output.
module pwm_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                target_on,
  input  logic                step,
  input  logic                load,
  output logic                pwm,
  output logic                at_target
);

  localparam logic [PWM_BITS-1:0] MAX_DUTY = {PWM_BITS{1'b1}};

  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS-1:0] duty_sh;
  logic [PWM_BITS-1:0] target;

  assign target    = target_on ? MAX_DUTY : '0;
  assign at_target = (duty == target);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      duty    <= '0;
      duty_sh <= '0;
      pwm     <= 1'b0;
    end else begin
      // target is always an endpoint, so its value alone gives the direction
      if (step && !at_target)
        duty <= target_on ? duty + 1'b1 : duty - 1'b1;
      if (load)
        duty_sh <= duty;
      pwm <= (pwm_cnt < duty_sh);
    end
  end

endmodule

// File: rtl/led_fader.sv
// RGB cross-fader: registers the sequencer colour code and ramps each
// channel's PWM duty linearly toward full-on or off.
//
//   state  | meaning
//   IDLE   | every channel at its target, prescaler held at 0
//   FADING | prescaler running, all channels step together on each wrap
module led_fader
  import led_pkg::*;
#(
  parameter int PWM_BITS    = 8,
  parameter int STEP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] colour,
  output logic       pwm_r,
  output logic       pwm_g,
  output logic       pwm_b,
  output logic       busy
);

  localparam logic [PWM_BITS-1:0] MAX_DUTY = {PWM_BITS{1'b1}};
  localparam int                  PS_W     = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(STEP_CYCLES - 1);

  logic [2:0]          colour_q;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PS_W-1:0]     presc;
  fade_state_t         state;
  logic [NUM_CH-1:0]   at_target;
  logic                step;
  logic                load;

  assign step = (state == FADING) && (presc == PS_LAST);
  assign load = (pwm_cnt == MAX_DUTY);
  assign busy = (state == FADING);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      colour_q <= '0;
      pwm_cnt  <= '0;
    end else begin
      colour_q <= colour;
      pwm_cnt  <= pwm_cnt + 1'b1;
    end
  end

  // A target change mid-fade keeps FADING and the prescaler phase untouched
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      presc <= '0;
    end else begin
      case (state)
        IDLE: begin
          presc <= '0;
          if (!(&at_target))
            state <= FADING;
        end
        FADING: begin
          if (&at_target) begin
            state <= IDLE;
            presc <= '0;
          end else if (step) begin
            presc <= '0;
          end else begin
            presc <= presc + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          presc <= '0;
        end
      endcase
    end
  end

  pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch_r (
    .clk       (clk),
    .rst       (rst),
    .pwm_cnt   (pwm_cnt),
    .target_on (colour_q[CH_R]),
    .step      (step),
    .load      (load),
    .pwm       (pwm_r),
    .at_target (at_target[CH_R])
  );

  pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch_g (
    .clk       (clk),
    .rst       (rst),
    .pwm_cnt   (pwm_cnt),
    .target_on (colour_q[CH_G]),
    .step      (step),
    .load      (load),
    .pwm       (pwm_g),
    .at_target (at_target[CH_G])
  );

  pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch_b (
    .clk       (clk),
    .rst       (rst),
    .pwm_cnt   (pwm_cnt),
    .target_on (colour_q[CH_B]),
    .step      (step),
    .load      (load),
    .pwm       (pwm_b),
    .at_target (at_target[CH_B])
  );

endmodule

// File: tb/tb_led_fader.sv
// Directed bench for led_fader with PWM_BITS=4, STEP_CYCLES=2.
module tb_led_fader;

  localparam int PB = 4;
  localparam int SC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] colour = 3'b000;
  logic       pwm_r, pwm_g, pwm_b, busy;

  int checks   = 0;
  int failures = 0;
  int edge_cnt;

  always #5 clk = ~clk;

  // edges since reset release; after edge k the DUT pwm_cnt equals k mod 16
  always @(posedge clk or negedge rst) begin
    if (!rst) edge_cnt <= 0;
    else      edge_cnt <= edge_cnt + 1;
  end

  led_fader #(.PWM_BITS(PB), .STEP_CYCLES(SC)) dut (
    .clk    (clk),
    .rst    (rst),
    .colour (colour),
    .pwm_r  (pwm_r),
    .pwm_g  (pwm_g),
    .pwm_b  (pwm_b),
    .busy   (busy)
  );

  // duty after edge k for a 0->15 fade whose colour was applied just after edge a
  function automatic int fade_val(input int k, input int a);
    int v;
    if (k < a + 2) return 0;
    v = (k - a - 2) / 2;
    if (v > 15) v = 15;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int bad;
    rst = 1'b0;
    colour = 3'b111;
    #1;
    checks++;
    if ({pwm_r, pwm_g, pwm_b, busy} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_initial: outputs=%b required=0000", {pwm_r, pwm_g, pwm_b, busy});
    end
    repeat (3) tick();
    checks++;
    if ({pwm_r, pwm_g, pwm_b, busy} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_held: outputs=%b required=0000", {pwm_r, pwm_g, pwm_b, busy});
    end
    colour = 3'b000;
    @(negedge clk) rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 48; i++) begin
      tick();
      if ({pwm_r, pwm_g, pwm_b, busy} !== 4'b0000) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL reset_release_idle: bad_cycles=%0d required=0", bad);
    end
  endtask

  task automatic test_fade_up;
    int a, rise, cnt, bad, hr, hg, hb;
    a = edge_cnt;
    colour = 3'b001;
    rise = -1; cnt = 0; bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (dut.u_ch_r.duty !== 4'(fade_val(edge_cnt, a))) bad++;
      if (busy === 1'b1) begin
        if (rise < 0) rise = edge_cnt;
        cnt++;
      end else if (rise >= 0) begin
        break;
      end
    end
    checks++;
    if (rise != a + 2) begin
      failures++;
      $display("FAIL fade_up_busy_rise: edge=%0d required=%0d", rise, a + 2);
    end
    checks++;
    if (cnt != 31) begin
      failures++;
      $display("FAIL fade_up_busy_len: cycles=%0d required=31", cnt);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL fade_up_duty_ramp: bad_cycles=%0d required=0", bad);
    end
    repeat (40) tick();
    hr = 0; hg = 0; hb = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      hr += int'(pwm_r); hg += int'(pwm_g); hb += int'(pwm_b);
    end
    checks++;
    if (hr != 15 || hg != 0 || hb != 0) begin
      failures++;
      $display("FAIL fade_up_high_time: r=%0d g=%0d b=%0d required r=15 g=0 b=0", hr, hg, hb);
    end
  endtask

  task automatic test_fade_down;
    int a, rise, cnt, bad, hr, hg, hb, exp_d;
    colour = 3'b111;
    repeat (70) tick();
    hr = 0; hg = 0; hb = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      hr += int'(pwm_r); hg += int'(pwm_g); hb += int'(pwm_b);
    end
    checks++;
    if (busy !== 1'b0 || hr != 15 || hg != 15 || hb != 15) begin
      failures++;
      $display("FAIL white_settled: busy=%b r=%0d g=%0d b=%0d required busy=0 and 15 each", busy, hr, hg, hb);
    end
    a = edge_cnt;
    colour = 3'b000;
    rise = -1; cnt = 0; bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      exp_d = 15 - fade_val(edge_cnt, a);
      if (dut.u_ch_r.duty !== 4'(exp_d) || dut.u_ch_g.duty !== 4'(exp_d) ||
          dut.u_ch_b.duty !== 4'(exp_d) || pwm_r !== pwm_g || pwm_r !== pwm_b) bad++;
      if (busy === 1'b1) begin
        if (rise < 0) rise = edge_cnt;
        cnt++;
      end else if (rise >= 0) begin
        break;
      end
    end
    checks++;
    if (cnt != 31) begin
      failures++;
      $display("FAIL fade_down_busy_len: cycles=%0d required=31", cnt);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL fade_down_lockstep: bad_cycles=%0d required=0", bad);
    end
    repeat (40) tick();
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if ({pwm_r, pwm_g, pwm_b} !== 3'b000) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL fade_down_final_low: high_cycles=%0d required=0", bad);
    end
  endtask

  task automatic test_reversal;
    int a, fall, bad, exp_d;
    a = edge_cnt;
    colour = 3'b001;
    repeat (14) tick();
    checks++;
    if (dut.u_ch_r.duty !== 4'd6) begin
      failures++;
      $display("FAIL reversal_peak: duty=%0d required=6", dut.u_ch_r.duty);
    end
    colour = 3'b000;
    fall = -1; bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (edge_cnt <= a + 15) exp_d = 6;
      else begin
        exp_d = 6 - (edge_cnt - a - 14) / 2;
        if (exp_d < 0) exp_d = 0;
      end
      if (dut.u_ch_r.duty !== 4'(exp_d)) bad++;
      if (busy !== 1'b1) begin
        fall = edge_cnt;
        break;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL reversal_ramp: bad_cycles=%0d required=0", bad);
    end
    checks++;
    if (fall != a + 27) begin
      failures++;
      $display("FAIL reversal_busy_fall: edge=%0d required=%0d", fall, a + 27);
    end
  endtask

  task automatic test_glitch_free;
    int a, m0, h;
    logic [15:0] got, want;
    for (int i = 0; i < 40; i++) begin
      if (edge_cnt % 16 == 4) break;
      tick();
    end
    a = edge_cnt;
    m0 = (a - 4) / 16;
    colour = 3'b001;
    for (int i = 0; i < 40; i++) begin
      if (edge_cnt >= 16 * (m0 + 1)) break;
      tick();
    end
    for (int p = 1; p <= 4; p++) begin
      h = fade_val(16 * (m0 + p) - 1, a);
      want = '0;
      for (int i = 0; i < 16; i++) begin
        tick();
        got[i] = pwm_r;
        want[i] = (i < h);
      end
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL glitch_period_%0d: pattern=%b required=%b", p, got, want);
      end
    end
  endtask

  task automatic test_reset_mid_fade;
    int a, rise, cnt, bad;
    colour = 3'b000;
    repeat (70) tick();
    for (int i = 0; i < 40; i++) begin
      if (edge_cnt % 16 == 0) break;
      tick();
    end
    a = edge_cnt;
    colour = 3'b001;
    repeat (20) tick();
    checks++;
    if (dut.u_ch_r.duty !== 4'd9 || pwm_r !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL midfade_precond: duty=%0d pwm_r=%b busy=%b required 9 1 1", dut.u_ch_r.duty, pwm_r, busy);
    end
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if ({pwm_r, pwm_g, pwm_b, busy} !== 4'b0000 || dut.u_ch_r.duty !== 4'd0) begin
      failures++;
      $display("FAIL midfade_async_clear: outputs=%b duty=%0d required 0000 and 0", {pwm_r, pwm_g, pwm_b, busy}, dut.u_ch_r.duty);
    end
    @(negedge clk) rst = 1'b1;
    rise = -1; cnt = 0; bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (dut.u_ch_r.duty !== 4'(fade_val(edge_cnt, 0))) bad++;
      if (busy === 1'b1) begin
        if (rise < 0) rise = edge_cnt;
        cnt++;
      end else if (rise >= 0) begin
        break;
      end
    end
    checks++;
    if (rise != 2 || cnt != 31 || bad != 0) begin
      failures++;
      $display("FAIL midfade_restart: rise=%0d len=%0d bad=%0d required 2 31 0", rise, cnt, bad);
    end
  endtask

  initial begin
    test_reset();
    test_fade_up();
    test_fade_down();
    test_reversal();
    test_glitch_free();
    test_reset_mid_fade();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
